// File: rtl/gear_pkg.sv
// Shared types, default widths and width helpers for the frame-aligned gearbox.
package gear_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_IN_W     = 32;
  localparam int unsigned DEF_OUT_W    = 20;
  localparam int unsigned DEF_FRAME_IN = 5;
  localparam int unsigned DEF_DISCARD  = 60;
  localparam int unsigned DEF_BUF_W    = 64;

  // Bits needed to hold the value n (never less than one).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gear_acc.sv
// Bit accumulator: appends variable-length chunks at the fill point and emits
// OUT_W-bit words from the bottom, at most one per cycle.
module gear_acc
  import gear_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned BUF_W = DEF_BUF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     clear,
  input  logic [IN_W-1:0]          app_data,
  input  logic [cnt_w(IN_W)-1:0]   app_len,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  output logic                     emit_c,
  output logic                     ovf_c
);

  localparam int unsigned CW  = BUF_W + IN_W;
  localparam int unsigned FW  = cnt_w(BUF_W);
  localparam int unsigned CFW = cnt_w(CW);

  logic [BUF_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d, base_fill;
  logic [CW-1:0]    base, cand, sel;
  logic [CFW-1:0]   cfill, sel_fill;
  logic             emit_full;

  // Candidate merge; on overflow the new chunk is dropped and only the old contents may emit
  always_comb begin
    base      = clear ? '0 : CW'(acc_q);
    base_fill = clear ? '0 : fill_q;
    cand      = base | (CW'(push ? app_data : '0) << base_fill);
    cfill     = CFW'(base_fill) + (push ? CFW'(app_len) : '0);
    emit_full = !clear && (cfill >= CFW'(OUT_W));
    ovf_c     = (cfill - (emit_full ? CFW'(OUT_W) : '0)) > CFW'(BUF_W);
    if (ovf_c) begin
      sel      = base;
      sel_fill = CFW'(base_fill);
      emit_c   = !clear && (sel_fill >= CFW'(OUT_W));
    end else begin
      sel      = cand;
      sel_fill = cfill;
      emit_c   = emit_full;
    end
    if (emit_c) begin
      acc_d  = BUF_W'(sel >> OUT_W);
      fill_d = FW'(sel_fill - CFW'(OUT_W));
    end else begin
      acc_d  = BUF_W'(sel);
      fill_d = FW'(sel_fill);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      fill_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      out_valid <= emit_c;
      if (emit_c) out_data <= sel[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/gear_frame.sv
// Frame-aligned gearbox: hunts for start-of-frame, strips the leading DISCARD
// bits of each frame and repacks the rest into OUT_W-bit words.
module gear_frame
  import gear_pkg::*;
#(
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned OUT_W    = DEF_OUT_W,
  parameter int unsigned FRAME_IN = DEF_FRAME_IN,
  parameter int unsigned DISCARD  = DEF_DISCARD,
  parameter int unsigned BUF_W    = DEF_BUF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             locked,
  output logic             err_align,
  output logic             err_ovf
);

  localparam int unsigned FRAME_BITS = FRAME_IN * IN_W;
  localparam int unsigned KOUT = (FRAME_BITS > DISCARD) ? (FRAME_BITS - DISCARD) / OUT_W : 1;
  localparam int unsigned WCW  = cnt_w(FRAME_IN);
  localparam int unsigned ECW  = cnt_w(KOUT);
  localparam int unsigned DW   = cnt_w(FRAME_BITS);
  localparam int unsigned LW   = cnt_w(IN_W);

  if (DISCARD >= FRAME_BITS) begin : g_bad_discard
    $fatal(1, "gear_frame: DISCARD must be below FRAME_IN*IN_W");
  end
  if (FRAME_BITS > DISCARD && ((FRAME_BITS - DISCARD) % OUT_W) != 0) begin : g_bad_ratio
    $fatal(1, "gear_frame: payload bits per frame must be a multiple of OUT_W");
  end
  if (BUF_W < OUT_W) begin : g_bad_buf
    $fatal(1, "gear_frame: BUF_W must be at least OUT_W");
  end

  state_t          state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wnext;
  logic [DW-1:0]   dleft_q, dcur, drop;
  logic [ECW-1:0]  ecnt_q;
  logic            push, clear, word0, emit_c, ovf_c;
  logic [IN_W-1:0] app_data;
  logic [LW-1:0]   app_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == HUNT && in_valid && in_sof) state_d = RUN;
  end

  // Word acceptance, realign detection and per-word discard trimming
  always_comb begin
    push     = in_valid && (state_q == RUN || in_sof);
    word0    = in_sof || (wcnt_q == '0);
    clear    = push && in_sof && (state_q == RUN) && (wcnt_q != '0);
    dcur     = word0 ? DW'(DISCARD) : dleft_q;
    drop     = (dcur > DW'(IN_W)) ? DW'(IN_W) : dcur;
    app_data = in_data >> drop;
    app_len  = LW'(DW'(IN_W) - drop);
    wnext    = word0 ? WCW'(1) : wcnt_q + WCW'(1);
  end

  gear_acc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .BUF_W (BUF_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .clear     (clear),
    .app_data  (app_data),
    .app_len   (app_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .emit_c    (emit_c),
    .ovf_c     (ovf_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q    <= '0;
      dleft_q   <= '0;
      ecnt_q    <= '0;
      out_sof   <= 1'b0;
      locked    <= 1'b0;
      err_align <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (push) begin
        wcnt_q  <= (wnext == WCW'(FRAME_IN)) ? '0 : wnext;
        dleft_q <= dcur - drop;
      end
      if (clear)       ecnt_q <= '0;
      else if (emit_c) ecnt_q <= (ecnt_q == ECW'(KOUT - 1)) ? '0 : ecnt_q + ECW'(1);
      out_sof   <= emit_c && (ecnt_q == '0);
      locked    <= (state_d == RUN);
      err_align <= err_align | clear;
      err_ovf   <= err_ovf | ovf_c;
    end
  end

endmodule

// File: tb/tb_gear_frame.sv
// Directed bench for gear_frame: default 32->20 gearbox plus a small
// 16->8 instance with an undersized buffer to provoke overflow.
module tb_gear_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid, in_sof;
  logic [19:0] out_data;
  logic        out_valid, out_sof, locked, err_align, err_ovf;

  logic [15:0] o_in_data;
  logic        o_in_valid, o_in_sof;
  logic [7:0]  o_out_data;
  logic        o_out_valid, o_out_sof, o_locked, o_err_align, o_err_ovf;

  always #5 clk = ~clk;

  gear_frame dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
    .locked(locked), .err_align(err_align), .err_ovf(err_ovf)
  );

  gear_frame #(.IN_W(16), .OUT_W(8), .FRAME_IN(5), .DISCARD(0), .BUF_W(8)) dut_ovf (
    .clk(clk), .rst(rst), .in_data(o_in_data), .in_valid(o_in_valid), .in_sof(o_in_sof),
    .out_data(o_out_data), .out_valid(o_out_valid), .out_sof(o_out_sof),
    .locked(o_locked), .err_align(o_err_align), .err_ovf(o_err_ovf)
  );

  typedef struct {
    logic [19:0] data;
    logic        sof;
    int          cyc;
  } ow_t;

  ow_t         got_q[$];
  logic [19:0] xd[$];
  logic        xs[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] fr[5];
  logic [19:0] e[5];
  logic [15:0] ow[5];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) got_q.push_back('{out_data, out_sof, cyc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0; in_sof = 1'b0; in_data = $urandom;
      o_in_valid = 1'b0; o_in_sof = 1'b0; o_in_data = 16'h0;
      tick();
    end
  endtask

  task automatic send(input logic [31:0] w, input logic sof);
    in_valid = 1'b1; in_sof = sof; in_data = w;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    got_q.delete();
    cyc = 0;
  endtask

  task automatic expect_frame();
    for (int k = 0; k < 5; k++) begin
      xd.push_back(e[k]);
      xs.push_back(k == 0);
    end
  endtask

  // Compare captured outputs against the expected queue; optionally check exact cycles
  task automatic check_q(input string tag, input bit chk_cyc, input int first_cyc);
    int n;
    check({tag, "_count"}, 64'(got_q.size()), 64'(xd.size()));
    n = (got_q.size() < xd.size()) ? got_q.size() : xd.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(got_q[i].data), 64'(xd[i]));
      check($sformatf("%s_sof%0d", tag, i), 64'(got_q[i].sof), 64'(xs[i]));
      if (chk_cyc) check($sformatf("%s_cyc%0d", tag, i), 64'(got_q[i].cyc), 64'(first_cyc + i));
    end
    xd.delete();
    xs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] od[6];
    fr[0] = 32'hA1B2C3D4; fr[1] = 32'h13579BDF; fr[2] = 32'h2468ACE0;
    fr[3] = 32'hDEADBEEF; fr[4] = 32'h0F1E2D3C;
    e[0] = {fr[2][15:0], fr[1][31:28]};
    e[1] = {fr[3][3:0],  fr[2][31:16]};
    e[2] = fr[3][23:4];
    e[3] = {fr[4][11:0], fr[3][31:24]};
    e[4] = fr[4][31:12];
    ow[0] = 16'h1234; ow[1] = 16'h5678; ow[2] = 16'h9ABC; ow[3] = 16'hDEF0; ow[4] = 16'h4321;
    od[0] = ow[0][7:0]; od[1] = ow[0][15:8]; od[2] = ow[2][7:0];
    od[3] = ow[2][15:8]; od[4] = ow[4][7:0]; od[5] = ow[4][15:8];

    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    o_in_valid = 1'b0; o_in_sof = 1'b0; o_in_data = '0;

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_sof", 64'(out_sof), 64'(0));
    check("rst_locked", 64'(locked), 64'(0));
    check("rst_err_align", 64'(err_align), 64'(0));
    check("rst_err_ovf", 64'(err_ovf), 64'(0));

    // Two back-to-back frames: outputs at cycles 3..12
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 5; k++) begin
        send(fr[k], k == 0);
        if (f == 0 && k == 0) check("s1_locked", 64'(locked), 64'(1));
      end
    end
    idle(6);
    expect_frame();
    expect_frame();
    check_q("s1", 1'b1, 3);

    // Hunting: words without in_sof are ignored
    do_reset();
    for (int k = 1; k < 4; k++) send(fr[k], 1'b0);
    check("s2_hunt_no_out", 64'(got_q.size()), 64'(0));
    check("s2_hunt_locked", 64'(locked), 64'(0));
    cyc = 0;
    for (int k = 0; k < 5; k++) send(fr[k], k == 0);
    check("s2_locked", 64'(locked), 64'(1));
    idle(6);
    expect_frame();
    check_q("s2", 1'b1, 3);

    // Random in_valid gaps (in_sof toggled while in_valid is low)
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 5; k++) begin
        send(fr[k], k == 0);
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
          in_valid = 1'b0; in_sof = 1'b1; in_data = $urandom;
          tick();
        end
      end
    end
    idle(8);
    expect_frame();
    expect_frame();
    check_q("s3", 1'b0, 0);
    check("s3_err_align", 64'(err_align), 64'(0));

    // Realign: in_sof at wcnt=3
    do_reset();
    for (int k = 0; k < 3; k++) send(fr[k], k == 0);
    check("s4_pre_err_align", 64'(err_align), 64'(0));
    send(fr[3], 1'b1);
    check("s4_err_align", 64'(err_align), 64'(1));
    for (int k = 1; k < 5; k++) send(fr[k], 1'b0);
    idle(6);
    check("s4_err_align_sticky", 64'(err_align), 64'(1));
    check("s4_err_ovf", 64'(err_ovf), 64'(0));
    xd.push_back(e[0]);
    xs.push_back(1'b1);
    expect_frame();
    check_q("s4", 1'b0, 0);

    // Reset asserted mid-frame clears everything immediately
    for (int k = 0; k < 3; k++) send(fr[k], k == 0);
    check("s6_pre_valid", 64'(out_valid), 64'(1));
    check("s6_pre_err_align", 64'(err_align), 64'(1));
    rst = 1'b1;
    #1;
    check("s6_out_valid", 64'(out_valid), 64'(0));
    check("s6_out_data", 64'(out_data), 64'(0));
    check("s6_out_sof", 64'(out_sof), 64'(0));
    check("s6_locked", 64'(locked), 64'(0));
    check("s6_err_align", 64'(err_align), 64'(0));
    #1;
    rst = 1'b0;
    got_q.delete();
    for (int k = 3; k < 5; k++) send(fr[k], 1'b0);
    for (int k = 0; k < 3; k++) send(fr[k], 1'b0);
    idle(2);
    check("s6_hunt_locked", 64'(locked), 64'(0));
    check("s6_hunt_no_out", 64'(got_q.size()), 64'(0));

    // Overflow instance: 16->8 with an 8-bit buffer
    do_reset();
    check("s5_rst_err_ovf", 64'(o_err_ovf), 64'(0));
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        o_in_valid = 1'b1; o_in_sof = (i == 0); o_in_data = ow[i];
        tick();
      end else begin
        idle(1);
      end
      check($sformatf("s5_valid%0d", i), 64'(o_out_valid), 64'(1));
      check($sformatf("s5_data%0d", i), 64'(o_out_data), 64'(od[i]));
      check($sformatf("s5_sof%0d", i), 64'(o_out_sof), 64'(i == 0));
      check($sformatf("s5_err_ovf%0d", i), 64'(o_err_ovf), 64'(i >= 1));
    end
    idle(1);
    check("s5_drained", 64'(o_out_valid), 64'(0));
    check("s5_err_ovf_sticky", 64'(o_err_ovf), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
